// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: launch/result bundle between the control FSM (master) and the mul/div unit (slave)
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master(output start, funct3, op_a, op_b, input busy, done, result);
  modport slave(input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: radix-2 iterative RV32M multiply/divide; ports clk, rst, bus (start/funct3/op_a/op_b in, busy/done/result out)
module muldiv_sequencer #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  muldiv_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state, next;
  logic [2:0] f3;
  logic [XLEN-1:0] a, b, mb, hi, lo, res, diff, fix_val;
  logic [4:0] cnt;
  logic sign_q, sign_r, sa, sb, div_zero, div_ovf, fast, ge;
  logic [XLEN:0] sum, sh;
  logic [2*XLEN-1:0] prod;
  // {hi, lo} is the product accumulator for multiplies and {rem, quo} for divides
  always_comb begin
    sa = a[XLEN-1] & (f3[2] ? ~f3[0] : f3[1:0] != 2'b11);
    sb = b[XLEN-1] & (f3[2] ? ~f3[0] : ~f3[1]);
    div_zero = f3[2] & (b == '0);
    div_ovf = f3[2] & ~f3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
    fast = div_zero | div_ovf;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
    sh = {hi, lo[XLEN-1]};
    ge = sh >= {1'b0, mb};
    diff = sh[XLEN-1:0] - mb;
    prod = sign_q ? -{hi, lo} : {hi, lo};
    fix_val = f3[2] ? (f3[1] ? (sign_r ? -hi : hi) : (sign_q ? -lo : lo))
                    : (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state == IDLE ? (bus.start ? PREP : IDLE)
         : state == PREP ? (fast ? DONE : ITER)
         : state == ITER ? (cnt == 5'd0 ? FIX : ITER)
         : state == FIX  ? DONE : IDLE;
  end
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.result = res;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      f3 <= '0;
      a <= '0;
      b <= '0;
      mb <= '0;
      hi <= '0;
      lo <= '0;
      res <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        f3 <= bus.funct3;
        a <= bus.op_a;
        b <= bus.op_b;
      end
      if (state == PREP) begin
        hi <= '0;
        lo <= sa ? -a : a;
        mb <= sb ? -b : b;
        sign_q <= sa ^ sb;
        sign_r <= sa;
        cnt <= 5'd31;
        // overflow quotient equals the dividend 0x80000000
        if (fast) res <= div_zero ? (f3[1] ? a : '1) : (f3[1] ? '0 : a);
      end
      if (state == ITER) begin
        cnt <= cnt - 5'd1;
        if (f3[2]) begin
          hi <= ge ? diff : sh[XLEN-1:0];
          lo <= {lo[XLEN-2:0], ge};
        end else begin
          hi <= sum[XLEN:1];
          lo <= {sum[0], lo[XLEN-1:1]};
        end
      end
      if (state == FIX) res <= fix_val;
    end
  end
endmodule
